// File: rtl/nonce_hub_pkg.sv
// Shared definitions for the nonce hub: word width, TX sequencer encoding
// and an elaboration-time log2 helper.
package nonce_hub_pkg;

   localparam int NONCE_W = 32;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_GUARD = 2'd1,
      TX_WAIT  = 2'd2
   } tx_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'sd1 <<< result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with first-word-fall-through head; flush empties it in
// one cycle and blocks any push or pop issued in that cycle.
module nonce_fifo
   import nonce_hub_pkg::*;
#(
   parameter int WIDTH = NONCE_W,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [clog2(DEPTH):0] level
);

   localparam int            PW       = clog2(DEPTH);
   localparam int            LW       = PW + 1;
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [LW-1:0] LVL_ZERO = LW'(0);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty     = (level_r == LVL_ZERO);
   assign full      = (level_r == LVL_FULL);
   assign push_ok_s = push & ~full & ~flush;
   assign pop_ok_s  = pop & ~empty & ~flush;
   assign dout      = mem_r[rd_ptr_r];
   assign level     = level_r;

   // Storage has no reset: the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
      end else if (flush) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/nonce_tx_arbiter.sv
// Round-robin collector of golden nonces from several miner cores, buffered
// through a FIFO and handed one at a time to the shared serial transmitter.
module nonce_tx_arbiter
   import nonce_hub_pkg::*;
#(
   parameter int SLAVES     = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [SLAVES-1:0]          new_nonces,
   input  logic [SLAVES*NONCE_W-1:0]  slave_nonces,
   input  logic                       flush,
   input  logic                       serial_busy,
   output logic                       serial_send,
   output logic [NONCE_W-1:0]         golden_nonce,
   output logic [clog2(FIFO_DEPTH):0] fifo_level,
   output logic [CNT_W-1:0]           drop_count,
   output logic                       active
);

   localparam int               SW       = (SLAVES > 1) ? clog2(SLAVES) : 1;
   localparam logic [SW-1:0]    RR_RESET = SW'(SLAVES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [NONCE_W-1:0] hold_r [SLAVES];
   logic [SLAVES-1:0]  pending_r;
   logic [SW-1:0]      rr_r;
   logic [CNT_W-1:0]   drop_r;
   tx_state_e          state_r;
   logic               send_r;
   logic [NONCE_W-1:0] golden_r;

   logic [SLAVES-1:0]  capture_s;
   logic [SLAVES-1:0]  grant_mask_s;
   logic [SW-1:0]      grant_idx_s;
   logic               grant_valid_s;
   logic               drop_s;
   logic               fifo_pop_s;
   logic               fifo_empty_s;
   logic               fifo_full_s;
   logic [NONCE_W-1:0] fifo_head_s;

   assign capture_s = new_nonces & ~{SLAVES{flush}};

   // First pending slave searching upward from one past the last grant.
   always_comb begin
      int            idx_i;
      logic [SW-1:0] idx_s;
      logic          hit_s;
      grant_valid_s = 1'b0;
      grant_idx_s   = {SW{1'b0}};
      idx_i         = 0;
      idx_s         = {SW{1'b0}};
      hit_s         = 1'b0;
      for (int k = 1; k <= SLAVES; k++) begin
         idx_i         = (int'(rr_r) + k) % SLAVES;
         idx_s         = SW'(idx_i);
         hit_s         = pending_r[idx_s] & ~grant_valid_s & ~flush & ~fifo_full_s;
         grant_idx_s   = hit_s ? idx_s : grant_idx_s;
         grant_valid_s = grant_valid_s | hit_s;
      end
   end

   // One-hot view of the grant for the pending and drop logic.
   always_comb begin
      grant_mask_s = {SLAVES{1'b0}};
      for (int i = 0; i < SLAVES; i++) begin
         grant_mask_s[i] = grant_valid_s & (grant_idx_s == SW'(i));
      end
   end

   // A pulse on a slave whose word is still waiting (and not leaving now) loses it.
   assign drop_s     = |(capture_s & pending_r & ~grant_mask_s);
   assign fifo_pop_s = (state_r == TX_IDLE) & ~fifo_empty_s & ~serial_busy & ~flush;

   // Capture registers, pending flags, round-robin pointer and drop counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_r <= {SLAVES{1'b0}};
         rr_r      <= RR_RESET;
         drop_r    <= {CNT_W{1'b0}};
         for (int i = 0; i < SLAVES; i++) begin
            hold_r[i] <= {NONCE_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < SLAVES; i++) begin
            if (capture_s[i]) begin
               hold_r[i] <= slave_nonces[i*NONCE_W +: NONCE_W];
            end
         end
         if (flush) begin
            pending_r <= {SLAVES{1'b0}};
         end else begin
            pending_r <= (pending_r & ~grant_mask_s) | capture_s;
         end
         if (grant_valid_s) begin
            rr_r <= grant_idx_s;
         end
         if (drop_s && (drop_r != CNT_MAX)) begin
            drop_r <= drop_r + CNT_ONE;
         end
      end
   end

   // TX sequencer; GUARD covers the transmitter's latency in raising busy.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r  <= TX_IDLE;
         send_r   <= 1'b0;
         golden_r <= {NONCE_W{1'b0}};
      end else begin
         case (state_r)
            TX_IDLE: begin
               if (fifo_pop_s) begin
                  golden_r <= fifo_head_s;
                  send_r   <= 1'b1;
                  state_r  <= TX_GUARD;
               end else begin
                  send_r   <= 1'b0;
               end
            end
            TX_GUARD: begin
               send_r  <= 1'b0;
               state_r <= TX_WAIT;
            end
            TX_WAIT: begin
               send_r <= 1'b0;
               if (!serial_busy) begin
                  state_r <= TX_IDLE;
               end
            end
            default: begin
               send_r  <= 1'b0;
               state_r <= TX_IDLE;
            end
         endcase
      end
   end

   nonce_fifo #(
      .WIDTH (NONCE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (grant_valid_s),
      .din     (hold_r[grant_idx_s]),
      .pop     (fifo_pop_s),
      .dout    (fifo_head_s),
      .empty   (fifo_empty_s),
      .full    (fifo_full_s),
      .level   (fifo_level)
   );

   assign serial_send  = send_r;
   assign golden_nonce = golden_r;
   assign drop_count   = drop_r;
   assign active       = ~fifo_empty_s | (|pending_r) | (state_r != TX_IDLE);

endmodule

// File: doc/nonce_tx_arbiter.md
Name: nonce_tx_arbiter

Overview:
- Collects golden-nonce pulses from SLAVES miner cores, which are already synchronised into the uart_clk domain, and buffers them in a small FIFO.
- Arbitrates round-robin between slaves and sequences the single shared serial_transmit instance through its send/busy handshake.
- Replaces the simple hub between the per-core nonce sync logic and sertx. Adds fairness, buffering, drop accounting and flush-on-new-work.

Parameters:
- SLAVES, 2: number of miner cores (1..8).
- FIFO_DEPTH, 8: nonce FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 8: width of the dropped-nonce counter (saturating).

Ports:
- clk  input  1  uart_clk domain clock.
- reset_n  input  1  synchronous, active-low reset.
- new_nonces  input  SLAVES  one-cycle pulse per slave, meaning a nonce is valid on slave_nonces.
- slave_nonces  input  SLAVES*32  slave i nonce on bits [i*32+31:i*32].
- flush  input  1  one-cycle pulse on new work (rx_done); discards stale nonces.
- serial_busy  input  1  busy from serial_transmit.
- serial_send  output  1  one-cycle send strobe to serial_transmit.
- golden_nonce  output  32  word to transmit; stable from the send strobe until the next send.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  output  CNT_W  number of nonces lost to overwrite; saturates at all-ones.
- active  output  1  high when the FIFO is non-empty, any pending bit is set, or the TX FSM is not IDLE (drives LED).

Behaviour:
- Reset (reset_n low at a clk edge): pending, hold registers, FIFO pointers, rr pointer (points at slave SLAVES-1, so slave 0 wins first), golden_nonce, drop_count, serial_send and state all go to 0/IDLE. Reset mid-transmission abandons the word. serial_transmit is not aborted.
- Capture stage, per slave i, on new_nonces[i]:
  - hold[i] <= slave word; pending[i] <= 1.
  - If pending[i] was already set and slave i is not granted this cycle, the old word is lost and drop_count increments by 1 (saturating).
- Grant stage, each cycle when pending is non-zero and the FIFO is not full:
  - Grant the first pending slave searching upward from rr+1, wrapping modulo SLAVES.
  - Push hold[g] to the FIFO and set rr <= g.
  - pending[g] clears, unless new_nonces[g] pulses in the same cycle. In that case pending stays set, hold[g] takes the new word, and no drop is counted.
  - At most one push per cycle.
- FIFO full: no grant. Pending words wait. A further pulse on an already-pending slave overwrites and counts a drop.
- Latency from new_nonces pulse to FIFO push is 1 cycle when uncontended. Push to serial_send is 1 cycle when the FSM is IDLE and serial_busy is low. Simultaneous push and pop on a non-empty FIFO is allowed and leaves the level unchanged.
- TX FSM:
  - IDLE: if the FIFO is non-empty and serial_busy=0, then golden_nonce <= head, pop, serial_send=1 for this cycle, go to GUARD.
  - GUARD: one cycle, ignores serial_busy (covers busy assertion latency), go to WAIT.
  - WAIT: stay while serial_busy=1; when serial_busy=0 go to IDLE.
  - Minimum spacing between serial_send strobes is 3 cycles. serial_send is never high in two consecutive cycles.
- Flush:
  - Clears pending, empties the FIFO, and blocks both grant and capture in that cycle. A new_nonces pulse coincident with flush is discarded and not counted as a drop.
  - Does not affect the TX FSM, golden_nonce or drop_count. A word already sent completes normally.
- Arithmetic: fifo_level ranges 0..FIFO_DEPTH. Pointers are clog2(FIFO_DEPTH) bits and wrap naturally. rr wraps modulo SLAVES (non-power-of-2 SLAVES handled explicitly).
- SLAVES=1: the arbiter degenerates to a fixed grant. Behaviour is otherwise identical.

Decomposition:
- Shared package (nonce_hub_pkg):
  - NONCE_W=32.
  - TX state encoding: IDLE=2'd0, GUARD=2'd1, WAIT=2'd2.
  - clog2 function.
- Sub-module nonce_fifo: synchronous FIFO with first-word-fall-through head output.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, reset_n, flush, push, din, pop, dout, empty, full, level.
- The round-robin search stays inline in nonce_tx_arbiter.

Test Plan:
- Single nonce: reset, then pulse slave0 with 32'hDEADBEEF while serial_busy stays low. Required: serial_send pulses 2 cycles later, golden_nonce=DEADBEEF, fifo_level returns to 0.
- Fairness: SLAVES=2, both slaves pulse in the same cycle (A0000000 on slave0, B1111111 on slave1), and serial_busy is held high for 20 cycles after each send. Required: send order is A0000000 then B1111111. The next simultaneous pair is also sent slave0-first, because rr=1 wraps to 0.
- Backpressure and overflow: FIFO_DEPTH=8, serial_busy held high, slave0 pulsed 10 times with values 1..10. Required: FIFO fills with 1..8, pending holds 10, drop_count=1 (value 9 lost). After busy is released, 1..8 then 10 are sent.
- Flush: 3 words queued and busy high, then flush pulses coinciding with a slave1 pulse. Required: fifo_level=0, nothing further is sent, drop_count unchanged, the in-progress golden_nonce is held stable.
- Handshake spacing: FIFO pre-loaded with 4 words, serial_busy modelled as serial_transmit (rises 1 cycle after send, lasts 100 cycles). Required: exactly 4 strobes, each at least 101 cycles apart, and never two strobes in consecutive cycles.
- Reset mid-WAIT: reset_n low for 1 cycle while in WAIT with 2 words queued. Required: all outputs 0, FIFO empty, and no serial_send after reset until a new nonce arrives.
